// File: rtl/conv3x3_frame_sched_if.sv
// Stream/handshake bundle between the pixel/weight source, the 3x3 frame
// scheduler and the 9-MAC conv datapath. The master modport is the
// environment side; the slave modport is the scheduler.
interface conv3x3_frame_sched_if;
  logic        start;
  logic        wt_valid;
  logic [7:0]  wt_data;
  logic        wt_ready;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        mac_valid_in;
  logic [71:0] mac_win;
  logic [71:0] mac_w;
  logic        mac_valid_out;
  logic [15:0] mac_result;
  logic        out_valid;
  logic [15:0] out_data;
  logic        busy;
  logic        frame_done;

  modport master (
    output start, wt_valid, wt_data, pix_valid, pix_data, mac_valid_out, mac_result,
    input  wt_ready, pix_ready, mac_valid_in, mac_win, mac_w, out_valid, out_data,
           busy, frame_done
  );

  modport slave (
    input  start, wt_valid, wt_data, pix_valid, pix_data, mac_valid_out, mac_result,
    output wt_ready, pix_ready, mac_valid_in, mac_win, mac_w, out_valid, out_data,
           busy, frame_done
  );
endinterface

// File: rtl/conv3x3_frame_sched.sv
// 3x3 convolution frame scheduler: loads nine weights, streams a raster
// frame through two line buffers and a 3x3 window, issues one window per
// pixel once a full window exists, and forwards datapath results.
// Optional build macro CONV_SCHED_RELU_EN clamps negative results to zero.
module conv3x3_frame_sched #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input logic clk,
  input logic rst,
  conv3x3_frame_sched_if.slave bus
);
  localparam int NTAP = 9;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int NOUT = (IMG_W - 2) * (IMG_H - 2);
  localparam int OW   = $clog2(NOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, RUN, DRAIN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 wcnt;
  logic [CW-1:0]              col;
  logic [RW-1:0]              row;
  logic [OW-1:0]              ocnt;
  logic [NTAP-1:0][7:0]       wts;
  logic [NTAP-1:0][7:0]       win;
  logic [7:0]                 lb0 [IMG_W];
  logic [7:0]                 lb1 [IMG_W];
  logic                       win_vld;
  logic                       out_vld;
  logic [15:0]                out_q;
  logic                       wt_acc, pix_acc, res_acc;
  logic                       last_col, last_row;
  logic [15:0]                res_val;

  assign wt_acc   = bus.wt_valid & bus.wt_ready;
  assign pix_acc  = bus.pix_valid & bus.pix_ready;
  assign res_acc  = bus.mac_valid_out & ((state_q == RUN) | (state_q == DRAIN));
  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));

`ifdef CONV_SCHED_RELU_EN
  assign res_val = bus.mac_result[15] ? 16'd0 : bus.mac_result;
`else
  assign res_val = bus.mac_result;
`endif

  assign bus.mac_valid_in = win_vld;
  assign bus.mac_win      = win;
  assign bus.mac_w        = wts;
  assign bus.out_valid    = out_vld;
  assign bus.out_data     = out_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_d        = state_q;
    bus.wt_ready   = 1'b0;
    bus.pix_ready  = 1'b0;
    bus.busy       = (state_q != IDLE);
    bus.frame_done = 1'b0;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD_W;
      LOAD_W: begin
        bus.wt_ready = 1'b1;
        if (wt_acc && wcnt == 4'd8) state_d = RUN;
      end
      RUN: begin
        bus.pix_ready = 1'b1;
        if (pix_acc && last_col && last_row) state_d = DRAIN;
      end
      DRAIN:   if (ocnt == OW'(NOUT)) state_d = DONE;
      DONE: begin
        bus.frame_done = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Weight, raster position and result counters; cleared on frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
      col  <= '0;
      row  <= '0;
      ocnt <= '0;
    end else if (state_q == IDLE && bus.start) begin
      wcnt <= '0;
      col  <= '0;
      row  <= '0;
      ocnt <= '0;
    end else begin
      if (wt_acc) wcnt <= wcnt + 4'd1;
      if (pix_acc) begin
        if (last_col) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (res_acc) ocnt <= ocnt + OW'(1);
    end
  end

  // Weights survive reset; they only change while loading.
  always_ff @(posedge clk) begin
    if (wt_acc) wts[wcnt] <= bus.wt_data;
  end

  // Line buffers: lb0 holds the previous row, lb1 the one before it.
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      lb1[col] <= lb0[col];
      lb0[col] <= bus.pix_data;
    end
  end

  // Window shift, window valid and registered result output.
  always_ff @(posedge clk) begin
    if (rst) begin
      win     <= '0;
      win_vld <= 1'b0;
      out_vld <= 1'b0;
      out_q   <= '0;
    end else begin
      win_vld <= pix_acc && (row >= RW'(2)) && (col >= CW'(2));
      if (pix_acc) begin
        for (int k = 0; k < 3; k++) begin
          win[3*k]   <= win[3*k+1];
          win[3*k+1] <= win[3*k+2];
        end
        win[2] <= lb1[col];
        win[5] <= lb0[col];
        win[8] <= bus.pix_data;
      end
      out_vld <= res_acc;
      if (res_acc) out_q <= res_val;
    end
  end
endmodule

// File: tb/tb_conv3x3_frame_sched.sv
// Bench for conv3x3_frame_sched on a 4x4 frame: a two-cycle datapath model,
// a direct convolution reference for windows and results, and a per-cycle
// compare process, plus literal expectations for the known frames.
module tb_conv3x3_frame_sched;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NOUT = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv3x3_frame_sched_if ifc();
  conv3x3_frame_sched #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int n_chk = 0;
  int n_fail = 0;

  logic signed [7:0] cw [9];
  logic signed [7:0] cp [W*H];

  logic [15:0] exp_out [256];
  logic [71:0] exp_win [256];
  int wr_o = 0, wr_w = 0, rd_o = 0, rd_w = 0;
  logic [15:0] got_out [256];
  int n_out = 0, n_done = 0;

  task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] dot(input logic [71:0] a, input logic [71:0] b);
    int s = 0;
    for (int k = 0; k < 9; k++) s += $signed(a[8*k +: 8]) * $signed(b[8*k +: 8]);
    return s[15:0];
  endfunction

  // Conv datapath: one register stage, result returns two cycles after the pixel.
  always @(posedge clk) begin
    if (rst) begin
      ifc.mac_valid_out <= 1'b0;
      ifc.mac_result    <= '0;
    end else begin
      ifc.mac_valid_out <= ifc.mac_valid_in;
      ifc.mac_result    <= dot(ifc.mac_win, ifc.mac_w);
    end
  end

  // Per-cycle compare of issued windows, results and frame completion.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      rd_o = wr_o;
      rd_w = wr_w;
    end else begin
      if (ifc.mac_valid_in) begin
        if (rd_w >= wr_w) chk("extra_window", ifc.mac_valid_in, 1'b0);
        else begin
          chk("mac_win", ifc.mac_win, exp_win[rd_w]);
          rd_w++;
        end
      end
      if (ifc.out_valid) begin
        if (rd_o >= wr_o) chk("extra_output", ifc.out_valid, 1'b0);
        else begin
          chk("out_data", ifc.out_data, exp_out[rd_o]);
          rd_o++;
        end
        got_out[n_out] = ifc.out_data;
        n_out++;
      end
      if (ifc.frame_done) begin
        n_done++;
        chk("done_after_all_outputs", rd_o, wr_o);
      end
    end
  end

  // Reference: direct 3x3 convolution of the frame, raster order of window centres.
  task automatic build_exp();
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        logic [71:0] wv;
        logic [15:0] v;
        int s;
        s = 0;
        for (int k = 0; k < 9; k++) begin
          logic signed [7:0] px;
          px = cp[(r - 2 + k / 3) * W + (c - 2 + k % 3)];
          wv[8*k +: 8] = px;
          s += px * cw[k];
        end
        v = s[15:0];
`ifdef CONV_SCHED_RELU_EN
        if (v[15]) v = 16'd0;
`endif
        exp_win[wr_w] = wv;
        wr_w++;
        exp_out[wr_o] = v;
        wr_o++;
      end
  endtask

  task automatic run_frame(input bit gaps, input bit start_mid, input int rst_after,
                           output int base);
    int i, guard, d0;
    bit acc;
    base = n_out;
    d0   = n_done;
    build_exp();
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    i = 0; guard = 0;
    while (i < 9 && guard < 200) begin
      ifc.wt_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.wt_data  = cw[i];
      @(negedge clk);
      if (gaps) begin
        chk("pix_ready_in_load_w", ifc.pix_ready, 1'b0);
        chk("wt_ready_in_load_w", ifc.wt_ready, 1'b1);
      end
      acc = ifc.wt_valid & ifc.wt_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    ifc.wt_valid = 1'b0;
    if (i < 9) chk("weight_load_timeout", i, 9);
    i = 0; guard = 0;
    while (i < W * H && guard < 400) begin
      ifc.pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.pix_data  = cp[i];
      ifc.start     = start_mid && (i == 8);
      @(negedge clk);
      acc = ifc.pix_valid & ifc.pix_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
      if (rst_after > 0 && i == rst_after) begin
        ifc.pix_valid = 1'b0;
        ifc.start     = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", ifc.busy, 1'b0);
        chk("rst_pix_ready", ifc.pix_ready, 1'b0);
        chk("rst_out_valid", ifc.out_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
    ifc.pix_valid = 1'b0;
    ifc.start     = 1'b0;
    if (i < W * H) chk("pixel_stream_timeout", i, W * H);
    guard = 0;
    while (n_done == d0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("frame_output_count", n_out - base, NOUT);
    chk("frame_done_count", n_done - d0, 1);
    chk("busy_after_frame", ifc.busy, 1'b0);
  endtask

  task automatic chk_lits(input string nm, input int base, input logic [15:0] l0,
                          input logic [15:0] l1, input logic [15:0] l2, input logic [15:0] l3);
    logic [15:0] lit [4];
    lit = '{l0, l1, l2, l3};
    for (int k = 0; k < 4; k++) chk(nm, got_out[base + k], lit[k]);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < W * H; k++) cp[k] = 8'(k + 1);
  endtask

  initial begin
    int b;
    ifc.start = 0; ifc.wt_valid = 0; ifc.wt_data = 0; ifc.pix_valid = 0; ifc.pix_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wt_ready", ifc.wt_ready, 1'b0);
    chk("reset_pix_ready", ifc.pix_ready, 1'b0);
    chk("reset_mac_valid_in", ifc.mac_valid_in, 1'b0);
    chk("reset_mac_win", ifc.mac_win, 72'd0);
    chk("reset_out_valid", ifc.out_valid, 1'b0);
    chk("reset_out_data", ifc.out_data, 16'd0);
    chk("reset_busy", ifc.busy, 1'b0);
    chk("reset_frame_done", ifc.frame_done, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    set_ramp();
    for (int k = 0; k < 9; k++) cw[k] = 8'sd1;
    run_frame(1'b0, 1'b0, 0, b);
    chk_lits("ones_lit", b, 16'd54, 16'd63, 16'd90, 16'd99);

    for (int k = 0; k < 9; k++) cw[k] = 8'sd0;
    cw[4] = 8'sd1;
    run_frame(1'b0, 1'b0, 0, b);
    chk_lits("center_lit", b, 16'd6, 16'd7, 16'd10, 16'd11);

    for (int k = 0; k < 9; k++) cw[k] = -8'sd1;
    run_frame(1'b0, 1'b0, 0, b);
`ifdef CONV_SCHED_RELU_EN
    chk_lits("neg_relu_lit", b, 16'd0, 16'd0, 16'd0, 16'd0);
`else
    chk_lits("neg_lit", b, 16'hFFCA, 16'hFFC1, 16'hFFA6, 16'hFF9D);
`endif

    for (int k = 0; k < 9; k++) cw[k] = 8'sd1;
    run_frame(1'b1, 1'b0, 0, b);
    chk_lits("gaps_lit", b, 16'd54, 16'd63, 16'd90, 16'd99);

    run_frame(1'b0, 1'b0, 7, b);
    run_frame(1'b0, 1'b0, 0, b);
    chk_lits("after_reset_lit", b, 16'd54, 16'd63, 16'd90, 16'd99);

    run_frame(1'b0, 1'b1, 0, b);
    chk_lits("start_in_run_lit", b, 16'd54, 16'd63, 16'd90, 16'd99);

    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 9; k++) cw[k] = 8'($urandom);
      for (int k = 0; k < W * H; k++) cp[k] = 8'($urandom);
      run_frame(1'(f % 2), 1'b0, 0, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
